// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative signed/unsigned divider.
package div_pkg;

  // Widest operand the helpers below handle; callers truncate to their own width.
  localparam int DIV_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  // Two's-complement negate. The low bits of the result are the correct
  // negation at any narrower width.
  function automatic logic [DIV_MAX_W-1:0] div_neg(input logic [DIV_MAX_W-1:0] v);
    return ~v + DIV_MAX_W'(1);
  endfunction

  // Magnitude of a value whose sign is supplied separately. Truncate the result
  // to the operand width; -2^(w-1) wraps to itself.
  function automatic logic [DIV_MAX_W-1:0] div_mag(input logic [DIV_MAX_W-1:0] v,
                                                   input logic              neg);
    return neg ? div_neg(v) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial
// subtract the divisor, and keep the difference when it is non-negative.
module div_step #(
  parameter int n = 8
) (
  input  logic [n:0]   prem_i,
  input  logic         din_i,
  input  logic [n-1:0] dsr_i,
  output logic [n:0]   prem_o,
  output logic         q_o
);

  logic [n+1:0] shifted;
  logic [n+1:0] diff;

  // Trial subtraction; the MSB of diff is the borrow.
  always_comb begin
    shifted = {prem_i, din_i};
    diff    = shifted - {2'b00, dsr_i};
    q_o     = ~diff[n+1];
    prem_o  = q_o ? diff[n:0] : shifted[n:0];
  end

endmodule

// File: rtl/signed_or_unsigned_div.sv
// Sequential N-bit divider, runtime-selectable signed/unsigned, restoring,
// one quotient bit per cycle. Constant latency: accept, n CALC, FIX, DONE.
module signed_or_unsigned_div
  import div_pkg::*;
#(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         arg_vld,
  output logic         arg_rdy,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         signed_div,
  output logic         res_vld,
  input  logic         res_rdy,
  output logic [n-1:0] quo,
  output logic [n-1:0] rem,
  output logic         div_by_zero
);

  localparam int CW = (n > 2) ? $clog2(n) : 1;

  div_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [n:0]   acc_q, acc_d;       // partial remainder
  logic [n-1:0] dvd_q, dvd_d;       // dividend shifting out, quotient shifting in
  logic [n-1:0] dsr_q, dsr_d;       // divisor magnitude
  logic [n-1:0] a_q, a_d;           // original dividend, returned on divide by zero
  logic         neg_quo_q, neg_quo_d;
  logic         neg_rem_q, neg_rem_d;
  logic         dz_q, dz_d;
  logic [n-1:0] quo_q, quo_d;
  logic [n-1:0] rem_q, rem_d;
  logic         dbz_q, dbz_d;

  logic [n:0]   step_prem;
  logic         step_q;

  div_step #(.n(n)) u_step (
    .prem_i (acc_q),
    .din_i  (dvd_q[n-1]),
    .dsr_i  (dsr_q),
    .prem_o (step_prem),
    .q_o    (step_q)
  );

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    dvd_d     = dvd_q;
    dsr_d     = dsr_q;
    a_d       = a_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dbz_d     = dbz_q;
    arg_rdy   = (state_q == IDLE);
    res_vld   = (state_q == DONE);

    unique case (state_q)
      IDLE: begin
        if (arg_vld) begin
          state_d   = CALC;
          cnt_d     = CW'(n - 1);
          acc_d     = '0;
          a_d       = a;
          dz_d      = (b == '0);
          // Signed mode works on magnitudes and fixes the signs afterwards.
          dvd_d     = n'(div_mag(DIV_MAX_W'(a), signed_div & a[n-1]));
          dsr_d     = n'(div_mag(DIV_MAX_W'(b), signed_div & b[n-1]));
          neg_quo_d = signed_div & (a[n-1] ^ b[n-1]);
          neg_rem_d = signed_div & a[n-1];
        end
      end
      CALC: begin
        acc_d = step_prem;
        dvd_d = {dvd_q[n-2:0], step_q};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = FIX;
      end
      FIX: begin
        state_d = DONE;
        dbz_d   = dz_q;
        if (dz_q) begin
          quo_d = '1;
          rem_d = a_q;
        end else begin
          quo_d = neg_quo_q ? n'(div_neg(DIV_MAX_W'(dvd_q))) : dvd_q;
          rem_d = neg_rem_q ? n'(div_neg(DIV_MAX_W'(acc_q[n-1:0]))) : acc_q[n-1:0];
        end
      end
      DONE: begin
        if (res_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      dvd_q     <= '0;
      dsr_q     <= '0;
      a_q       <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      dvd_q     <= dvd_d;
      dsr_q     <= dsr_d;
      a_q       <= a_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dbz_q     <= dbz_d;
    end
  end

  assign quo         = quo_q;
  assign rem         = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: doc/signed_or_unsigned_div.md
# signed_or_unsigned_div

Sequential N-bit divider with a runtime `signed_mul`-style mode bit (`signed_div`), producing quotient and remainder. It is the inverse companion of the team's signed/unsigned multiplier. The datapath is a restoring, one-bit-per-cycle iterative divider. It sits between a valid/ready producer of operands and a valid/ready consumer of results. Latency is constant and independent of operand values.

## Interface

- `n`, default 8: operand, quotient and remainder width; must be at least 2.
- `clk`  input  1  clock; all state changes on the rising edge.
- `rst`  input  1  reset, asynchronous, active-low.
- `arg_vld`  input  1  operands valid.
- `arg_rdy`  output  1  divider can accept operands; high only in IDLE.
- `a`  input  n  dividend.
- `b`  input  n  divisor.
- `signed_div`  input  1  1: two's-complement division; 0: unsigned division.
- `res_vld`  output  1  result valid; high only in DONE.
- `res_rdy`  input  1  consumer takes the result.
- `quo`  output  n  quotient, registered.
- `rem`  output  n  remainder, registered.
- `div_by_zero`  output  1  set with the result when `b == 0`.

## Operation

- **States and transitions**
  - IDLE -> CALC on `arg_vld && arg_rdy`. The edge captures `a`, `b` and `signed_div`.
  - CALC runs exactly n cycles; an iteration counter counts down from n-1 to 0.
  - CALC -> FIX when the counter reaches 0.
  - FIX -> DONE after 1 cycle.
  - DONE -> IDLE on `res_rdy`.
- **Operand preparation at capture**
  - Signed mode: store magnitudes |a| and |b| as n-bit unsigned values, plus `neg_q = a[n-1] ^ b[n-1]` and `neg_r = a[n-1]`.
  - Unsigned mode: store the operands unchanged and clear both negate flags.
- **CALC iteration**
  - Form `{rem_acc, dividend}` shifted left by one.
  - Trial-subtract the divisor from the upper n+1 bits.
  - If the result is non-negative, keep the difference and shift in quotient bit 1; otherwise restore and shift in 0.
- **FIX**
  - Quotient is negated if `neg_q`; remainder is negated if `neg_r`.
  - This gives truncation toward zero: quotient and remainder match the language `/` and `%` for the selected signedness.
- **Divide by zero**
  - `quo` = all ones, `rem` = original `a`, `div_by_zero` = 1, in both modes.
  - Latency is unchanged, and the sign fix is bypassed.
- **Signed overflow (-2^(n-1) / -1)**
  - `quo` = 100…0, `rem` = 0, `div_by_zero` = 0.
  - This is the natural result of the magnitude path wrapping; no flag is raised.
- **Input and output stability**
  - Inputs are ignored outside the accept edge.
  - `quo`, `rem` and `div_by_zero` are stable while `res_vld && !res_rdy`.

## Timing

- **Reset values**
  - Reset asserted: state IDLE, `arg_rdy` = 1, `res_vld` = 0, `quo` = 0, `rem` = 0, `div_by_zero` = 0.
  - Reset asserted mid-operation aborts it immediately; no partial result is ever presented.
- **Latency**
  - Accept edge T: `res_vld` is high after edge T+n+1 (9 cycles for n=8).
- **Throughput**
  - One division per n+3 cycles when `res_rdy` is held high: accept, n CALC, FIX, DONE, then IDLE.
  - No new accept happens in the DONE cycle, because `arg_rdy` = 0 there.
- **Backpressure**
  - DONE holds indefinitely while `res_rdy` is low.
  - `arg_rdy` rises the cycle after the `res_rdy` handshake.
- **Handshake input rules**
  - `res_rdy` is ignored outside DONE.
  - `arg_vld` is ignored outside IDLE.

## Structure

- **Package `div_pkg`**
  - State enum typedef: IDLE, CALC, FIX, DONE.
  - Helper function for n-bit two's-complement negate and magnitude.
- **Sub-module `div_step`**
  - Combinational single restoring iteration.
  - Inputs: partial remainder (n+1 bits), next dividend bit, divisor.
  - Outputs: new partial remainder, quotient bit.
  - Top level instantiates it once and iterates it over time.

## Test plan

All scenarios use n=8.

- **Unsigned:** `a`=200, `b`=7, `signed_div`=0 -> `quo`=28, `rem`=4; `res_vld` rises exactly 9 cycles after the accept edge.
- **Signed vs unsigned, same bits:** `a`=0xF9, `b`=0x02.
  - Signed -> `quo`=0xFD (-3), `rem`=0xFF (-1).
  - Unsigned -> `quo`=0x7C, `rem`=0x01.
- **Signed overflow and mixed signs:**
  - 0x80 / 0xFF -> `quo`=0x80, `rem`=0x00, `div_by_zero`=0.
  - 7 / -2 -> `quo`=0xFD, `rem`=0x01.
- **Divide by zero:** `a`=0x35, `b`=0, in both modes -> `quo`=0xFF, `rem`=0x35, `div_by_zero`=1; latency still 9 cycles.
- **Backpressure:** hold `res_rdy`=0 for 5 cycles in DONE -> `quo`/`rem` stable and `arg_rdy`=0 throughout; release -> `arg_rdy`=1 on the next cycle; back-to-back ops give period 11 cycles.
- **Reset mid-CALC:** assert `rst` low at iteration 3 -> `res_vld`=0 and outputs=0 immediately, `arg_rdy`=1 after release; the next operation (100/9) gives `quo`=11, `rem`=1.
